// File: rtl/c432_irq_pkg.sv
// Shared types and constants for the c432 interrupt sequencer.
// The vector layout is {grp[1:0], chan[3:0]}; the clear line index is grp*9+chan.
package c432_irq_pkg;
  localparam int NUM_GRP = 3;
  localparam int NUM_CH  = 9;
  localparam int VEC_W   = 6;
  localparam int CLR_W   = 27;

  typedef enum logic [2:0] {IDLE, QUAL, PRESENT, CLEAR, HOLD} state_e;
  typedef enum logic [1:0] {GRP_A = 2'd0, GRP_B = 2'd1, GRP_C = 2'd2} grp_e;

  // grp*9 is built as grp*8 + grp to keep the index arithmetic multiplier-free
  function automatic logic [CLR_W-1:0] clr_onehot(input logic [VEC_W-1:0] vec);
    logic [4:0] idx;
    idx = {vec[5:4], 3'b000} + {3'b000, vec[5:4]} + {1'b0, vec[3:0]};
    return CLR_W'(1) << idx;
  endfunction
endpackage

// File: rtl/c432_irq_qualifier.sv
// Priority-resolves the encoder flags and tracks how long the resolved sample
// has been stable against a held snapshot.
module c432_irq_qualifier
  import c432_irq_pkg::*;
#(
  parameter int STABLE_CYC = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_flags,   // {C, B, A}
  input  logic [3:0]       i_chan,
  input  logic             i_load,
  input  logic             i_track,
  output logic [VEC_W-1:0] o_cur,
  output logic [VEC_W-1:0] o_snap,
  output logic             o_req,
  output logic             o_illegal,
  output logic             o_stable
);
  localparam logic [3:0] STB_M1 = 4'(STABLE_CYC - 1);

  grp_e             w_grp;
  logic             w_match;
  logic [VEC_W-1:0] r_snap;
  logic [3:0]       r_cnt;

  always_comb begin
    w_grp = GRP_C;
    if (i_flags[0])      w_grp = GRP_A;
    else if (i_flags[1]) w_grp = GRP_B;
  end

  assign o_req     = |i_flags;
  assign o_illegal = o_req && (i_chan > 4'd8);
  assign o_cur     = {w_grp, i_chan};
  assign o_snap    = r_snap;
  assign w_match   = (o_cur == r_snap);
  assign o_stable  = o_req && !o_illegal && w_match && (r_cnt == STB_M1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snap <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_snap <= o_cur;
      r_cnt  <= 4'd1;
    end else if (i_track && o_req && !o_illegal) begin
      // any change in the sample restarts the stability window
      if (!w_match) begin
        r_snap <= o_cur;
        r_cnt  <= 4'd1;
      end else if (r_cnt != STB_M1) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/c432_irq_sequencer.sv
// Qualifies c432 encoder output, hands one vector to the CPU via valid/ready,
// pulses the matching one-hot clear, then holds off. Option: C432_IRQ_SVC_COUNT_EN.
module c432_irq_sequencer
  import c432_irq_pkg::*;
#(
  parameter int STABLE_CYC  = 3,
  parameter int HOLDOFF_CYC = 2,
  parameter int CNT_W       = 16
) (
  input  logic             id_clk,
  input  logic             id_rst,
  input  logic             id_223gat,
  input  logic             id_329gat,
  input  logic             id_370gat,
  input  logic             id_421gat,
  input  logic             id_430gat,
  input  logic             id_431gat,
  input  logic             id_432gat,
  output logic             irq_valid,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ready,
  output logic [CLR_W-1:0] clr_pulse,
  output logic             busy,
  output logic             err_illegal
`ifdef C432_IRQ_SVC_COUNT_EN
  ,
  output logic [CNT_W-1:0] svc_cnt_a,
  output logic [CNT_W-1:0] svc_cnt_b,
  output logic [CNT_W-1:0] svc_cnt_c
`endif
);
  localparam logic [3:0] HLD_M1 = 4'(HOLDOFF_CYC - 1);

  if (STABLE_CYC < 1 || STABLE_CYC > 15 || HOLDOFF_CYC < 0 || HOLDOFF_CYC > 15 || CNT_W < 1)
  begin : g_bad_param
    $error("c432_irq_sequencer: parameter out of range");
  end

  state_e           r_state, w_nxt_state;
  logic             r_valid, w_nxt_valid;
  logic [VEC_W-1:0] r_vec, w_nxt_vec;
  logic [CLR_W-1:0] r_clr, w_nxt_clr;
  logic             r_err, w_nxt_err;
  logic [3:0]       r_hcnt, w_nxt_hcnt;
  logic             w_load, w_track, w_xfer;
  logic [VEC_W-1:0] w_cur, w_snap;
  logic             w_req, w_illegal, w_stable;

  c432_irq_qualifier #(.STABLE_CYC(STABLE_CYC)) u_qual (
    .i_clk     (id_clk),
    .i_rst     (id_rst),
    .i_flags   ({id_370gat, id_329gat, id_223gat}),
    .i_chan    ({id_421gat, id_430gat, id_431gat, id_432gat}),
    .i_load    (w_load),
    .i_track   (w_track),
    .o_cur     (w_cur),
    .o_snap    (w_snap),
    .o_req     (w_req),
    .o_illegal (w_illegal),
    .o_stable  (w_stable)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_valid;
    w_nxt_vec   = r_vec;
    w_nxt_clr   = '0;
    w_nxt_err   = 1'b0;
    w_nxt_hcnt  = r_hcnt;
    w_load      = 1'b0;
    w_track     = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_illegal) begin
          w_nxt_err = 1'b1;
        end else if (w_req) begin
          if (STABLE_CYC == 1) begin
            w_nxt_vec   = w_cur;
            w_nxt_valid = 1'b1;
            w_nxt_state = PRESENT;
          end else begin
            w_load      = 1'b1;
            w_nxt_state = QUAL;
          end
        end
      end
      QUAL: begin
        w_track = 1'b1;
        if (w_illegal) begin
          w_nxt_err   = 1'b1;
          w_nxt_state = IDLE;
        end else if (!w_req) begin
          w_nxt_state = IDLE;
        end else if (w_stable) begin
          w_nxt_vec   = w_snap;
          w_nxt_valid = 1'b1;
          w_nxt_state = PRESENT;
        end
      end
      PRESENT: begin
        if (r_valid && irq_ready) begin
          w_xfer      = 1'b1;
          w_nxt_valid = 1'b0;
          w_nxt_clr   = clr_onehot(r_vec);
          w_nxt_state = CLEAR;
        end
      end
      CLEAR: begin
        w_nxt_hcnt = '0;
        if (HOLDOFF_CYC == 0) w_nxt_state = IDLE;
        else                  w_nxt_state = HOLD;
      end
      HOLD: begin
        if (r_hcnt == HLD_M1) w_nxt_state = IDLE;
        else                  w_nxt_hcnt  = r_hcnt + 4'd1;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge id_clk) begin
    if (id_rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_clr   <= '0;
      r_err   <= 1'b0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_valid <= w_nxt_valid;
      r_vec   <= w_nxt_vec;
      r_clr   <= w_nxt_clr;
      r_err   <= w_nxt_err;
      r_hcnt  <= w_nxt_hcnt;
    end
  end

  assign irq_valid   = r_valid;
  assign irq_vec     = r_vec;
  assign clr_pulse   = r_clr;
  assign err_illegal = r_err;
  assign busy        = (r_state != IDLE);

`ifdef C432_IRQ_SVC_COUNT_EN
  logic [CNT_W-1:0] r_cnt_a, r_cnt_b, r_cnt_c;

  // saturating per-group transfer counts; only reset clears them
  always_ff @(posedge id_clk) begin
    if (id_rst) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_cnt_c <= '0;
    end else if (w_xfer) begin
      case (r_vec[5:4])
        2'd0:    if (r_cnt_a != '1) r_cnt_a <= r_cnt_a + 1'b1;
        2'd1:    if (r_cnt_b != '1) r_cnt_b <= r_cnt_b + 1'b1;
        2'd2:    if (r_cnt_c != '1) r_cnt_c <= r_cnt_c + 1'b1;
        default: ;
      endcase
    end
  end

  assign svc_cnt_a = r_cnt_a;
  assign svc_cnt_b = r_cnt_b;
  assign svc_cnt_c = r_cnt_c;
`endif
endmodule

// File: doc/c432_irq_sequencer.md
Name: c432_irq_sequencer

Overview:
- Sequential stage directly downstream of the c432 27-channel priority interrupt encoder.
- Consumes the encoder's group flags (A/B/C) and 4-bit channel code.
- Qualifies them as stable for a programmable number of cycles, then presents one 6-bit vector to the CPU over a valid/ready handshake.
- After acceptance, issues a one-cycle one-hot clear to the serviced request source and waits a hold-off period before sampling again.

Parameters:
- STABLE_CYC, 3, consecutive identical samples required before presenting (legal 1..15).
- HOLDOFF_CYC, 2, idle cycles after the clear pulse before re-sampling (legal 0..15).
- CNT_W, 16, width of the service counters (used only with the optional feature).

Ports:
- id_clk  in  1  single clock; all state updates on the rising edge.
- id_rst  in  1  reset, synchronous, active-high.
- id_223gat  in  1  group A request pending (active-high).
- id_329gat  in  1  group B request pending (active-high).
- id_370gat  in  1  group C request pending (active-high).
- id_421gat, id_430gat, id_431gat, id_432gat  in  1 each  channel code, MSB..LSB; legal 0..8.
- irq_valid  out  1  vector available.
- irq_vec  out  6  {grp[1:0], chan[3:0]}, with grp A=0, B=1, C=2.
- irq_ready  in  1  CPU accepts the vector.
- clr_pulse  out  27  one-hot clear, bit index grp*9+chan.
- busy  out  1  high whenever state != IDLE.
- err_illegal  out  1  one-cycle pulse when an illegal channel code is sampled.
- svc_cnt_a/b/c  out  CNT_W each  present only with the optional feature.

Behaviour:
- Reset: state=IDLE; irq_valid=0; irq_vec=0; clr_pulse=0; err_illegal=0; all counters=0. Reset mid-operation aborts at the next edge; no clr_pulse is issued.
- Sample: cur = {grp, chan}. Group priority if several flags are high: A > B > C. "No request" means all three flags are low.
- Illegal sample: a group flag is high and chan > 8. Effect: err_illegal pulses 1 cycle, the FSM goes to IDLE, and nothing is presented.
- IDLE:
  - On a legal request: snapshot <= cur, cnt <= 1, go to QUAL.
  - If STABLE_CYC == 1: go directly to PRESENT instead.
- QUAL, on each edge:
  - No request: go to IDLE.
  - cur != snapshot: snapshot <= cur, cnt <= 1.
  - Match and cnt == STABLE_CYC-1: irq_vec <= snapshot, irq_valid <= 1, go to PRESENT.
  - Match otherwise: cnt++.
- Latency: with a constant legal input, irq_valid is visible after exactly STABLE_CYC edges counted from the first sampling edge.
- PRESENT:
  - irq_vec is held; inputs are ignored.
  - Transfer occurs on an edge with irq_valid && irq_ready, including when ready is already high in the first valid cycle.
  - On transfer: irq_valid <= 0, clr_pulse <= onehot(grp*9+chan), go to CLEAR.
  - No timeout; valid holds indefinitely.
- CLEAR: exactly one cycle with clr_pulse asserted. Next edge: clr_pulse <= 0; go to HOLD (cnt <= 0), or to IDLE if HOLDOFF_CYC == 0.
- HOLD: count HOLDOFF_CYC edges, then go to IDLE. Inputs are ignored.
- Throughput: one vector per STABLE_CYC + 2 + HOLDOFF_CYC cycles minimum, plus CPU stall time.

Optional Feature:
- Macro: C432_IRQ_SVC_COUNT_EN.
- Defined: svc_cnt_a/b/c ports exist. Each counter increments on a transfer for its group, saturates at all-ones, and is cleared only by id_rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package c432_irq_pkg holds:
  - state enum {IDLE, QUAL, PRESENT, CLEAR, HOLD};
  - group code typedef (GRP_A=0, GRP_B=1, GRP_C=2);
  - constants NUM_GRP=3, NUM_CH=9, VEC_W=6, CLR_W=27.
- One sub-module is natural: c432_irq_qualifier. It owns the snapshot/compare/count logic and reports stable, none, and illegal.

Test Plan:
- Constant group B, chan 5, STABLE_CYC=3 → irq_valid after 3 edges, irq_vec=6'b01_0101; ready=1 → next cycle clr_pulse[14]=1 for exactly 1 cycle; busy low after 2 HOLD cycles.
- Chan toggles 2→3 in 2nd QUAL cycle (group A) → count restarts; valid 3 edges after the change with irq_vec=6'b00_0011.
- A and C flags high together, chan 0 → irq_vec=6'b00_0000, clr_pulse[0]; chan code 12 with A high → err_illegal single pulse, no valid.
- irq_ready held low 20 cycles, inputs changed meanwhile → vector unchanged; accept on cycle 21 → clr_pulse for the original vector only.
- id_rst asserted during CLEAR → next edge clr_pulse=0, irq_valid=0, busy=0; with C432_IRQ_SVC_COUNT_EN, counters=0.
